// File: rtl/sim_run_pkg.sv
// Shared types and constants for the simulation / bring-up run controller.
package sim_run_pkg;

  typedef enum logic [2:0] {
    ST_NONE    = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_HANG    = 3'd4
  } run_status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } ctrl_state_e;

  localparam logic [31:0] TOHOST_PASS = 32'd1;

  // Hart-ID width; a single hart still gets a 1-bit ID field.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_run_ctrl_if.sv
// Core-side connection of the run controller: per-hart reset/busy and the tohost store port.
interface sim_run_ctrl_if #(
  parameter int unsigned N_HARTS = 1
);
  localparam int unsigned HART_W = sim_run_pkg::id_width(N_HARTS);

  logic [N_HARTS-1:0] core_rstn;
  logic [N_HARTS-1:0] core_busy;
  logic               tohost_valid;
  logic [HART_W-1:0]  tohost_hart;
  logic [31:0]        tohost_data;

  // master: the core side; slave: the run controller.
  modport master (
    input  core_rstn,
    output core_busy, tohost_valid, tohost_hart, tohost_data
  );

  modport slave (
    output core_rstn,
    input  core_busy, tohost_valid, tohost_hart, tohost_data
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: sequences hart reset, counts run cycles and turns tohost
// stores, timeouts and idle hangs into a registered verdict.
module sim_run_ctrl
  import sim_run_pkg::*;
#(
  parameter  int unsigned N_HARTS        = 1,
  parameter  int unsigned RST_CYCLES     = 1,
  parameter  int unsigned TIMEOUT_CYCLES = 134,
  parameter  int unsigned IDLE_CYCLES    = 16,
  parameter  int unsigned CNT_W          = 32,
  localparam int unsigned HART_W         = id_width(N_HARTS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  sim_run_ctrl_if.slave     core,
  output logic              done_o,
  output run_status_e       status_o,
  output logic [HART_W-1:0] fail_hart_o,
  output logic [30:0]       fail_code_o,
  output logic [CNT_W-1:0]  cycles_o
);

  localparam int unsigned RST_W  = (RST_CYCLES  > 0) ? $clog2(RST_CYCLES + 1)  : 1;
  localparam int unsigned IDLE_W = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;

  ctrl_state_e        state_d, state_q;
  logic [RST_W-1:0]   rst_cnt_d, rst_cnt_q;
  logic [N_HARTS-1:0] pass_d, pass_q;
  logic               rstn_d, rstn_q;
  logic               done_d, done_q;
  run_status_e        status_d, status_q;
  logic [HART_W-1:0]  fail_hart_d, fail_hart_q;
  logic [30:0]        fail_code_d, fail_code_q;

  logic [IDLE_W-1:0]  idle_cnt;
  logic [CNT_W-1:0]   cycle_cnt;
  logic               start_ok_c;
  logic               store_ok_c, is_pass_c, is_fail_c, idle_now_c;
  logic               timeout_hit_c, hang_hit_c;
  logic [N_HARTS-1:0] hart_bit_c, pass_upd_c;
  run_status_e        verdict_c;

  assign start_ok_c = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Tohost decode; stores naming a hart that does not exist are dropped.
  always_comb begin
    store_ok_c    = core.tohost_valid && (32'(core.tohost_hart) < N_HARTS);
    hart_bit_c    = N_HARTS'(1) << core.tohost_hart;
    is_pass_c     = store_ok_c && (core.tohost_data == TOHOST_PASS);
    is_fail_c     = store_ok_c && core.tohost_data[0] && (core.tohost_data != TOHOST_PASS);
    pass_upd_c    = pass_q | (is_pass_c ? hart_bit_c : '0);
    idle_now_c    = (core.core_busy == '0) && !core.tohost_valid;
    timeout_hit_c = ((CNT_W+1)'(cycle_cnt) + (CNT_W+1)'(1)) == (CNT_W+1)'(TIMEOUT_CYCLES);
    hang_hit_c    = idle_now_c && ((32'(idle_cnt) + 32'd1) == IDLE_CYCLES);
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (start_ok_c),
    .inc_i (state_q == S_RUN),
    .cnt_o (cycle_cnt)
  );

  sat_counter #(.W(IDLE_W)) u_idle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i ((state_q != S_RUN) || !idle_now_c),
    .inc_i (state_q == S_RUN),
    .cnt_o (idle_cnt)
  );

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    pass_d      = pass_q;
    rstn_d      = rstn_q;
    done_d      = done_q;
    status_d    = status_q;
    fail_hart_d = fail_hart_q;
    fail_code_d = fail_code_q;
    verdict_c   = ST_NONE;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok_c) begin
          state_d     = S_RESET;
          rst_cnt_d   = '0;
          pass_d      = '0;
          rstn_d      = 1'b0;
          done_d      = 1'b0;
          status_d    = ST_NONE;
          fail_hart_d = '0;
          fail_code_d = '0;
        end
      end
      S_RESET: begin
        if (32'(rst_cnt_q) == RST_CYCLES) begin
          state_d = S_RUN;
          rstn_d  = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      S_RUN: begin
        pass_d = pass_upd_c;
        if (is_fail_c) begin
          verdict_c   = ST_FAIL;
          fail_hart_d = core.tohost_hart;
          fail_code_d = core.tohost_data[31:1];
        end else if (&pass_upd_c) begin
          verdict_c = ST_PASS;
        end else if (timeout_hit_c) begin
          verdict_c = ST_TIMEOUT;
        end else if (hang_hit_c) begin
          verdict_c = ST_HANG;
        end
        // Any verdict freezes the harts on the same edge it is latched.
        if (verdict_c != ST_NONE) begin
          state_d  = S_DONE;
          status_d = verdict_c;
          done_d   = 1'b1;
          rstn_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      pass_q      <= '0;
      rstn_q      <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= ST_NONE;
      fail_hart_q <= '0;
      fail_code_q <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      pass_q      <= pass_d;
      rstn_q      <= rstn_d;
      done_q      <= done_d;
      status_q    <= status_d;
      fail_hart_q <= fail_hart_d;
      fail_code_q <= fail_code_d;
    end
  end

  assign core.core_rstn = {N_HARTS{rstn_q}};
  assign done_o         = done_q;
  assign status_o       = status_q;
  assign fail_hart_o    = fail_hart_q;
  assign fail_code_o    = fail_code_q;
  assign cycles_o       = cycle_cnt;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: two instances (1 hart / RST 3, 2 harts / RST 1) checked
// each cycle against a rule-level model, plus directed literal checks.
module tb_sim_run_ctrl;
  import sim_run_pkg::*;

  localparam int unsigned TO_C   = 134;
  localparam int unsigned IDLE_C = 16;

  logic clk;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   chk_on = 0;

  logic        t_rst   [2];
  logic        t_start [2];
  logic [1:0]  t_busy  [2];
  logic        t_valid [2];
  logic        t_hart  [2];
  logic [31:0] t_data  [2];

  logic [1:0]  o_rstn   [2];
  logic        o_done   [2];
  logic [2:0]  o_status [2];
  logic        o_fhart  [2];
  logic [30:0] o_fcode  [2];
  logic [31:0] o_cycles [2];

  sim_run_ctrl_if #(.N_HARTS(1)) if0 ();
  sim_run_ctrl_if #(.N_HARTS(2)) if1 ();

  assign if0.core_busy    = t_busy[0][0];
  assign if0.tohost_valid = t_valid[0];
  assign if0.tohost_hart  = t_hart[0];
  assign if0.tohost_data  = t_data[0];
  assign if1.core_busy    = t_busy[1];
  assign if1.tohost_valid = t_valid[1];
  assign if1.tohost_hart  = t_hart[1];
  assign if1.tohost_data  = t_data[1];
  assign o_rstn[0] = {1'b0, if0.core_rstn};
  assign o_rstn[1] = if1.core_rstn;

  sim_run_ctrl #(.N_HARTS(1), .RST_CYCLES(3), .TIMEOUT_CYCLES(TO_C),
                 .IDLE_CYCLES(IDLE_C), .CNT_W(32)) u_dut0 (
    .clk_i(clk), .rst_i(t_rst[0]), .start_i(t_start[0]), .core(if0.slave),
    .done_o(o_done[0]), .status_o(o_status[0]), .fail_hart_o(o_fhart[0]),
    .fail_code_o(o_fcode[0]), .cycles_o(o_cycles[0]));

  sim_run_ctrl #(.N_HARTS(2), .RST_CYCLES(1), .TIMEOUT_CYCLES(TO_C),
                 .IDLE_CYCLES(IDLE_C), .CNT_W(32)) u_dut1 (
    .clk_i(clk), .rst_i(t_rst[1]), .start_i(t_start[1]), .core(if1.slave),
    .done_o(o_done[1]), .status_o(o_status[1]), .fail_hart_o(o_fhart[1]),
    .fail_code_o(o_fcode[1]), .cycles_o(o_cycles[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Model: a run is "active" from an accepted start until its verdict; harts are
  // released once RST+1 edges have passed since the start edge.
  bit          m_active [2];
  bit          m_run    [2];
  int          m_edges  [2];
  bit          m_done   [2];
  int          m_status [2];
  logic        m_fhart  [2];
  logic [30:0] m_fcode  [2];
  int          m_cycles [2];
  int          m_idle   [2];
  bit   [1:0]  m_pass   [2];

  task automatic m_clear(input int d);
    m_done[d] = 0; m_status[d] = 0; m_fhart[d] = 0; m_fcode[d] = '0;
    m_cycles[d] = 0; m_idle[d] = 0; m_pass[d] = '0; m_edges[d] = 0; m_run[d] = 0;
  endtask

  task automatic model_step(input int d);
    int  n  = (d == 0) ? 1 : 2;
    int  rc = (d == 0) ? 3 : 1;
    bit  st_ok, busy_any, all_pass;
    int  verdict;
    if (t_rst[d]) begin
      m_clear(d); m_active[d] = 0;
    end else if (t_start[d] && !m_active[d]) begin
      m_clear(d); m_active[d] = 1;
    end else if (m_active[d] && !m_run[d]) begin
      m_edges[d]++;
      if (m_edges[d] == rc + 1) m_run[d] = 1;
    end else if (m_active[d]) begin
      m_cycles[d]++;
      st_ok = t_valid[d] && (int'(t_hart[d]) < n);
      if (st_ok && t_data[d] == 32'd1) m_pass[d][t_hart[d]] = 1'b1;
      busy_any = (d == 0) ? t_busy[d][0] : (|t_busy[d]);
      if (!busy_any && !t_valid[d]) m_idle[d]++; else m_idle[d] = 0;
      all_pass = (d == 0) ? m_pass[d][0] : (&m_pass[d]);
      verdict = 0;
      if (st_ok && t_data[d][0] && t_data[d] != 32'd1) begin
        verdict = 2; m_fhart[d] = t_hart[d]; m_fcode[d] = t_data[d][31:1];
      end else if (all_pass)                    verdict = 1;
      else if (m_cycles[d] == int'(TO_C))       verdict = 3;
      else if (m_idle[d] == int'(IDLE_C))       verdict = 4;
      if (verdict != 0) begin
        m_status[d] = verdict; m_done[d] = 1; m_active[d] = 0; m_run[d] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d);
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rstn%0d", d),   32'(o_rstn[d]),   m_run[d] ? ((d == 0) ? 32'd1 : 32'd3) : 32'd0);
        chk($sformatf("done%0d", d),   32'(o_done[d]),   32'(m_done[d]));
        chk($sformatf("status%0d", d), 32'(o_status[d]), 32'(m_status[d]));
        chk($sformatf("fhart%0d", d),  32'(o_fhart[d]),  32'(m_fhart[d]));
        chk($sformatf("fcode%0d", d),  32'(o_fcode[d]),  32'(m_fcode[d]));
        chk($sformatf("cycles%0d", d), o_cycles[d],      32'(m_cycles[d]));
      end
    end
  end

  task automatic do_start(input int d);
    t_start[d] = 1'b1;
    @(negedge clk);
    t_start[d] = 1'b0;
  endtask

  task automatic store(input int d, input logic h, input logic [31:0] v);
    t_valid[d] = 1'b1; t_hart[d] = h; t_data[d] = v;
    @(negedge clk);
    t_valid[d] = 1'b0; t_hart[d] = 1'b0; t_data[d] = '0;
  endtask

  task automatic run_to(input int d, input int c);
    int k = 0;
    while (!(m_run[d] && m_cycles[d] == c) && k < 1000) begin
      @(negedge clk); k++;
    end
    if (k >= 1000) chk($sformatf("run_to%0d_%0d_bound", d, c), 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int d);
    int k = 0;
    while (!m_done[d] && k < 400) begin
      @(negedge clk); k++;
    end
    if (k >= 400) chk($sformatf("wait_done%0d_bound", d), 32'd0, 32'd1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      t_rst[d] = 1'b1; t_start[d] = 1'b0; t_busy[d] = 2'b11;
      t_valid[d] = 1'b0; t_hart[d] = 1'b0; t_data[d] = '0;
    end
    repeat (3) @(negedge clk);
    chk_on = 1;
    chk("rst_rstn", 32'(o_rstn[0]), 32'd0);
    chk("rst_done", 32'(o_done[1]), 32'd0);
    chk("rst_status", 32'(o_status[0]), 32'd0);
    chk("rst_cycles", o_cycles[1], 32'd0);
    t_rst[0] = 1'b0; t_rst[1] = 1'b0;
    @(negedge clk);

    // Single hart, RST_CYCLES=3: release timing, ignored stores, PASS at cycle 40.
    do_start(0);
    repeat (3) @(negedge clk);
    chk("a_rstn_low_k3", 32'(o_rstn[0]), 32'd0);
    @(negedge clk);
    chk("a_rstn_high_k4", 32'(o_rstn[0]), 32'd1);
    run_to(0, 9);
    store(0, 1'b0, 32'h40);
    chk("a_even_ignored", 32'(o_done[0]), 32'd0);
    run_to(0, 19);
    store(0, 1'b1, 32'd1);
    chk("a_oor_ignored", 32'(o_status[0]), 32'd0);
    run_to(0, 39);
    store(0, 1'b0, 32'd1);
    chk("a_pass_status", 32'(o_status[0]), 32'(ST_PASS));
    chk("a_pass_cycles", o_cycles[0], 32'd40);
    chk("a_pass_rstn", 32'(o_rstn[0]), 32'd0);
    store(0, 1'b0, 32'd3);
    repeat (2) @(negedge clk);
    chk("a_done_hold", 32'(o_status[0]), 32'(ST_PASS));

    // Restart from DONE, then HANG at cycle 20.
    do_start(0);
    chk("b_restart_status", 32'(o_status[0]), 32'd0);
    chk("b_restart_cycles", o_cycles[0], 32'd0);
    run_to(0, 4);
    t_busy[0] = 2'b00;
    wait_done(0);
    @(negedge clk);
    chk("b_hang_status", 32'(o_status[0]), 32'(ST_HANG));
    chk("b_hang_cycles", o_cycles[0], 32'd20);

    // Busy pulse at cycle 12 restarts the idle count: HANG at 28.
    t_busy[0] = 2'b01;
    do_start(0);
    run_to(0, 4);
    t_busy[0] = 2'b00;
    run_to(0, 11);
    t_busy[0] = 2'b01;
    @(negedge clk);
    t_busy[0] = 2'b00;
    wait_done(0);
    @(negedge clk);
    chk("c_hang_cycles", o_cycles[0], 32'd28);
    t_busy[0] = 2'b01;

    // Reset mid-run, then start coincident with reset.
    do_start(0);
    run_to(0, 10);
    t_rst[0] = 1'b1;
    @(negedge clk);
    t_rst[0] = 1'b0;
    chk("d_rst_rstn", 32'(o_rstn[0]), 32'd0);
    chk("d_rst_cycles", o_cycles[0], 32'd0);
    t_start[0] = 1'b1; t_rst[0] = 1'b1;
    @(negedge clk);
    t_start[0] = 1'b0; t_rst[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("d_rst_wins", 32'(o_rstn[0]), 32'd0);

    // Two harts, RST_CYCLES=1: PASS needs both harts.
    do_start(1);
    run_to(1, 9);
    store(1, 1'b0, 32'd1);
    chk("e_half_pass", 32'(o_done[1]), 32'd0);
    run_to(1, 19);
    store(1, 1'b1, 32'd1);
    chk("e_pass_status", 32'(o_status[1]), 32'(ST_PASS));
    chk("e_pass_cycles", o_cycles[1], 32'd20);

    // Only hart 0 passes, busy held: TIMEOUT.
    do_start(1);
    run_to(1, 9);
    store(1, 1'b0, 32'd1);
    wait_done(1);
    @(negedge clk);
    chk("f_to_status", 32'(o_status[1]), 32'(ST_TIMEOUT));
    chk("f_to_cycles", o_cycles[1], 32'd134);

    // FAIL from hart 1 with code 3.
    do_start(1);
    chk("g_restart_status", 32'(o_status[1]), 32'd0);
    run_to(1, 9);
    store(1, 1'b0, 32'd1);
    run_to(1, 14);
    store(1, 1'b1, 32'h0000_0007);
    chk("g_fail_status", 32'(o_status[1]), 32'(ST_FAIL));
    chk("g_fail_hart", 32'(o_fhart[1]), 32'd1);
    chk("g_fail_code", 32'(o_fcode[1]), 32'd3);

    // FAIL on the timeout cycle wins over TIMEOUT.
    do_start(1);
    chk("h_restart_code", 32'(o_fcode[1]), 32'd0);
    run_to(1, 133);
    store(1, 1'b0, 32'h0000_0005);
    chk("h_fail_status", 32'(o_status[1]), 32'(ST_FAIL));
    chk("h_fail_code", 32'(o_fcode[1]), 32'd2);
    chk("h_fail_cycles", o_cycles[1], 32'd134);

    repeat (3) @(negedge clk);
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
